ciphertext_serializer: RTL and testbench

- Downstream stage of the XOR encryption unit.
- Captures the completed MSG_SIZE-bit ciphertext once the encrypt stage reports terminal count.
- Shifts the ciphertext out one bit per accepted transfer over a valid/ready handshake.
- Drives the chip's serial output pin and a done flag for the top-level controller.

---
 rtl/ciphertext_serializer_if.sv | 25 ++
 rtl/ciphertext_serializer.sv | 112 +++++++++++
 tb/tb_ciphertext_serializer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ciphertext_serializer_if.sv
// Handshake bundle between the encrypt stage, the serializer and the serial sink.
// master is the serializer side; slave is the surrounding environment.
interface ciphertext_serializer_if #(
  parameter int unsigned MSG_SIZE = 64,
  parameter int unsigned CW       = $clog2(MSG_SIZE) + 1
);
  logic [MSG_SIZE-1:0] iCiphertext;
  logic [CW-1:0]       iCiphertext_counter;
  logic                iReady;
  logic                oSerial_bit;
  logic                oValid;
  logic [CW-1:0]       oBit_counter;
  logic                oDone;
  logic                oBusy;

  modport master (
    input  iCiphertext, iCiphertext_counter, iReady,
    output oSerial_bit, oValid, oBit_counter, oDone, oBusy
  );

  modport slave (
    output iCiphertext, iCiphertext_counter, iReady,
    input  oSerial_bit, oValid, oBit_counter, oDone, oBusy
  );
endinterface

// File: rtl/ciphertext_serializer.sv
// Captures a completed ciphertext word and shifts it out LSB first over valid/ready.
// Define CIPHER_SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module ciphertext_serializer #(
  parameter int unsigned MSG_SIZE = 64,
  parameter int unsigned CW       = $clog2(MSG_SIZE) + 1
) (
  input logic                     clk,
  input logic                     rst_n,
  input logic                     ena,
  ciphertext_serializer_if.master bus
);
  typedef enum logic [1:0] {StIdle, StShift, StFinish, StWaitRearm} state_e;

  localparam logic [CW-1:0] Complete = CW'(MSG_SIZE);
  localparam logic [CW-1:0] DataLast = CW'(MSG_SIZE - 1);
`ifdef CIPHER_SERIALIZER_PARITY_EN
  localparam logic [CW-1:0] LastCnt  = Complete;
`else
  localparam logic [CW-1:0] LastCnt  = DataLast;
`endif

  state_e              state_q;
  logic [MSG_SIZE-1:0] shreg_q;
  logic                armed_q;
  logic                serial_bit_q;
  logic                valid_q;
  logic [CW-1:0]       bit_counter_q;
  logic                done_q;
  logic                busy_q;
`ifdef CIPHER_SERIALIZER_PARITY_EN
  logic                parity_q;
`endif

  logic xfer;
  logic complete;

  assign xfer     = valid_q & bus.iReady;
  // Counter values above MSG_SIZE never match, so they read as not complete.
  assign complete = (bus.iCiphertext_counter == Complete);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      armed_q       <= 1'b1;
      serial_bit_q  <= 1'b0;
      valid_q       <= 1'b0;
      bit_counter_q <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
`ifdef CIPHER_SERIALIZER_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else if (!ena) begin
      done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (armed_q && complete) begin
            shreg_q       <= bus.iCiphertext;
            serial_bit_q  <= bus.iCiphertext[0];
            armed_q       <= 1'b0;
            valid_q       <= 1'b1;
            busy_q        <= 1'b1;
            bit_counter_q <= '0;
            state_q       <= StShift;
`ifdef CIPHER_SERIALIZER_PARITY_EN
            parity_q      <= ^bus.iCiphertext;
`endif
          end
        end
        StShift: begin
          if (xfer) begin
            shreg_q       <= shreg_q >> 1;
            serial_bit_q  <= shreg_q[1];
            bit_counter_q <= bit_counter_q + CW'(1);
`ifdef CIPHER_SERIALIZER_PARITY_EN
            if (bit_counter_q == DataLast) serial_bit_q <= parity_q;
`endif
            if (bit_counter_q == LastCnt) begin
              serial_bit_q <= 1'b0;
              valid_q      <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= StFinish;
            end
          end
        end
        StFinish: begin
          done_q  <= 1'b0;
          state_q <= StWaitRearm;
        end
        StWaitRearm: begin
          // Re-arm only after the encrypt stage restarts, so a held terminal count
          // is captured once.
          if (bus.iCiphertext_counter == '0) begin
            armed_q       <= 1'b1;
            bit_counter_q <= '0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.oSerial_bit  = serial_bit_q;
  assign bus.oValid       = valid_q;
  assign bus.oBit_counter = bit_counter_q;
  assign bus.oDone        = done_q;
  assign bus.oBusy        = busy_q;
endmodule

// File: tb/tb_ciphertext_serializer.sv
// Directed bench for ciphertext_serializer: LSB-first order, handshake stalls, single
// capture per terminal count, mid-shift reset, enable freeze and optional parity bit.
module tb_ciphertext_serializer;
  localparam int unsigned MSG_SIZE = 64;
  localparam int unsigned CW       = $clog2(MSG_SIZE) + 1;
`ifdef CIPHER_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk;
  logic rst_n;
  logic ena;

  ciphertext_serializer_if #(.MSG_SIZE(MSG_SIZE), .CW(CW)) bus ();

  ciphertext_serializer #(.MSG_SIZE(MSG_SIZE), .CW(CW)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Receives one word starting from a negedge before capture; ends one cycle after oDone.
  task automatic recv_word(input logic [MSG_SIZE-1:0] word, input bit toggle,
                           input int pause_at);
    int c;
    int idx;
    int pause_left;
    bit paused;
    bit hold;
    logic prev_bit;
    logic [CW-1:0] frozen;
    int nbits;
    nbits = MSG_SIZE + PAR;
    bus.iReady = !toggle;
    c = 0;
    while (!bus.oValid && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("valid_rise", bus.oValid, 1);
    check("busy_rise", bus.oBusy, 1);
    bus.iCiphertext = ~word;  // must not disturb the captured word
    idx = 0; pause_left = 0; paused = 0; hold = 0; prev_bit = 0; frozen = '0;
    for (c = 0; c < 400; c++) begin
      if (bus.oDone) break;
      if (hold) check("stable_bit", bus.oSerial_bit, prev_bit);
      if (pause_left > 0) begin
        check("ena_freeze_cnt", bus.oBit_counter, frozen);
        check("ena_freeze_valid", bus.oValid, 1);
        pause_left--;
      end else if (idx == pause_at && !paused) begin
        paused = 1;
        pause_left = 10;
        frozen = bus.oBit_counter;
      end
      ena = (pause_left == 0);
      bus.iReady = toggle ? ((c + 1) % 2 == 0) : 1'b1;
      if (ena && bus.oValid && bus.iReady) begin
        if (idx < MSG_SIZE) check("bit", bus.oSerial_bit, word[idx]);
        else check("parity_bit", bus.oSerial_bit, ^word);
        idx++;
      end
      hold = bus.oValid && !(bus.iReady && ena);
      prev_bit = bus.oSerial_bit;
      @(negedge clk);
    end
    check("done_seen", bus.oDone, 1);
    check("bit_total", idx, nbits);
    check("bit_counter_end", bus.oBit_counter, nbits);
    check("valid_end", bus.oValid, 0);
    check("busy_end", bus.oBusy, 0);
    if (pause_at < 0) check("latency", c, (toggle ? 2 : 1) * nbits);
    @(negedge clk);
    check("done_pulse", bus.oDone, 0);
    check("bit_counter_hold", bus.oBit_counter, nbits);
  endtask

  task automatic rearm();
    bus.iCiphertext_counter = '0;
    @(negedge clk);
    check("rearm_clear", bus.oBit_counter, 0);
  endtask

  initial begin
    int n;
    int c;
    rst_n = 1'b0;
    ena = 1'b1;
    bus.iCiphertext = '0;
    bus.iCiphertext_counter = '0;
    bus.iReady = 1'b0;
    #1;
    check("rst_serial", bus.oSerial_bit, 0);
    check("rst_valid", bus.oValid, 0);
    check("rst_count", bus.oBit_counter, 0);
    check("rst_done", bus.oDone, 0);
    check("rst_busy", bus.oBusy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic word, ready always high.
    bus.iCiphertext = 64'h0123_4567_89AB_CDEF;
    bus.iCiphertext_counter = CW'(MSG_SIZE);
    recv_word(64'h0123_4567_89AB_CDEF, 1'b0, -1);

    // Terminal count held: no second capture.
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.oValid || bus.oDone || bus.oBusy) n++;
    end
    check("single_capture", n, 0);
    rearm();

    // Same word with ready toggling.
    bus.iCiphertext = 64'h0123_4567_89AB_CDEF;
    bus.iCiphertext_counter = CW'(MSG_SIZE);
    recv_word(64'h0123_4567_89AB_CDEF, 1'b1, -1);
    rearm();

    // Above-range counter is not complete.
    bus.iCiphertext = 64'hFFFF_FFFF_0000_0000;
    bus.iCiphertext_counter = CW'(MSG_SIZE + 1);
    repeat (3) @(negedge clk);
    check("over_range_ignored", bus.oBusy, 0);
    bus.iCiphertext_counter = CW'(MSG_SIZE);
    recv_word(64'hFFFF_FFFF_0000_0000, 1'b0, -1);
    rearm();

    // Reset at bit 20, then a fresh capture.
    bus.iCiphertext = 64'hDEAD_BEEF_CAFE_F00D;
    bus.iCiphertext_counter = CW'(MSG_SIZE);
    bus.iReady = 1'b1;
    c = 0;
    while (bus.oBit_counter != CW'(20) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("reach_bit20", bus.oBit_counter, 20);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_serial", bus.oSerial_bit, 0);
    check("mid_rst_valid", bus.oValid, 0);
    check("mid_rst_count", bus.oBit_counter, 0);
    check("mid_rst_busy", bus.oBusy, 0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.oDone) n++;
    end
    check("mid_rst_no_done", n, 0);
    rst_n = 1'b1;
    recv_word(64'hDEAD_BEEF_CAFE_F00D, 1'b0, -1);
    rearm();

    // Enable dropped for 10 cycles mid-shift.
    bus.iCiphertext = 64'hA5A5_0F0F_3C3C_9669;
    bus.iCiphertext_counter = CW'(MSG_SIZE);
    recv_word(64'hA5A5_0F0F_3C3C_9669, 1'b0, 30);
    rearm();

`ifdef CIPHER_SERIALIZER_PARITY_EN
    bus.iCiphertext = 64'h0000_0000_0000_0007;
    bus.iCiphertext_counter = CW'(MSG_SIZE);
    recv_word(64'h0000_0000_0000_0007, 1'b0, -1);
    rearm();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
